// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and its width.
package serial_subtractor_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
   input  logic x_i,
   input  logic y_i,
   input  logic bin_i,
   output logic d_o,
   output logic bout_o
);

   assign d_o    = x_i ^ y_i ^ bin_i;
   assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one full-subtractor cell reused over WIDTH cycles.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             br_q, br_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fs_d;
   logic             fs_bout;

   full_subtractor u_fs (
      .x_i    (a_sr_q[0]),
      .y_i    (b_sr_q[0]),
      .bin_i  (br_q),
      .d_o    (fs_d),
      .bout_o (fs_bout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               br_d    = bin;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // Result bits enter at the MSB of the minuend register as its LSBs are consumed.
            a_sr_d = {fs_d, a_sr_q[WIDTH-1:1]};
            b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
            br_d   = fs_bout;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               diff_d  = {fs_d, a_sr_q[WIDTH-1:1]};
               bout_d  = fs_bout;
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy = (state_q == S_SHIFT);
   assign done = (state_q == S_DONE);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed and random 8-bit runs plus an exhaustive 4-bit sweep.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, bin8, busy8, done8, bout8;
   logic [7:0] a8, b8, diff8;
   logic       start4, bin4, busy4, done4, bout4;
   logic [3:0] a4, b4, diff4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
      .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain signed arithmetic, then wrap to the operand width.
   function automatic void ref_sub(input int w, input int av, input int bv, input int bi,
                                   output int d, output int bo);
      int r;
      r  = av - bv - bi;
      bo = (r < 0) ? 1 : 0;
      d  = r & ((1 << w) - 1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic bi, input int poke);
      int cyc, busy_n, ed, eb;
      ref_sub(8, int'(av), int'(bv), int'(bi), ed, eb);
      a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      a8 = ~av; b8 = 8'($urandom); bin8 = ~bi;
      cyc = 0; busy_n = 0;
      while (!done8 && cyc < 40) begin
         if (busy8) busy_n++;
         if (poke > 0 && cyc == poke) begin
            start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
         end else begin
            start8 = 1'b0;
         end
         tick();
         cyc++;
      end
      start8 = 1'b0;
      check("done8_seen", 32'(done8), 1);
      check("lat8", cyc, 8);
      check("busy8_cnt", busy_n, 8);
      check("busy_done_excl", 32'(busy8), 0);
      check("diff8", 32'(diff8), ed);
      check("bout8", 32'(bout8), eb);
      $display("run8 a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d (exp %02h %0d)",
               av, bv, bi, diff8, bout8, ed, eb);
      // Start raised during DONE must be ignored.
      start8 = 1'b1; a8 = 8'h77;
      tick();
      start8 = 1'b0;
      check("done8_single", 32'(done8), 0);
      check("busy8_after_done", 32'(busy8), 0);
      tick();
      check("busy8_start_in_done", 32'(busy8), 0);
      check("diff8_hold", 32'(diff8), ed);
      check("bout8_hold", 32'(bout8), eb);
   endtask

   task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic bi);
      int cyc, ed, eb;
      ref_sub(4, int'(av), int'(bv), int'(bi), ed, eb);
      a4 = av; b4 = bv; bin4 = bi; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      cyc = 0;
      while (!done4 && cyc < 20) begin
         tick();
         cyc++;
      end
      check("lat4", cyc, 4);
      check("diff4", 32'(diff4), ed);
      check("bout4", 32'(bout4), eb);
      $display("run4 a=%0h b=%0h bin=%0d -> diff=%0h bout=%0d (exp %0h %0d)",
               av, bv, bi, diff4, bout4, ed, eb);
      tick();
   endtask

   initial begin
      int done_n;
      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
      repeat (3) tick();
      check("rst_busy8", 32'(busy8), 0);
      check("rst_done8", 32'(done8), 0);
      check("rst_diff8", 32'(diff8), 0);
      check("rst_bout8", 32'(bout8), 0);
      check("rst_busy4", 32'(busy4), 0);
      check("rst_diff4", 32'(diff4), 0);
      rst = 1'b0;
      tick();

      run8(8'h05, 8'h03, 1'b0, 0);
      run8(8'h03, 8'h05, 1'b0, 0);
      run8(8'h00, 8'h00, 1'b1, 0);
      run8(8'hFF, 8'hFF, 1'b0, 0);
      run8(8'h05, 8'h03, 1'b0, 3);

      // Reset mid-run: aborted, outputs cleared, no done pulse afterwards.
      a8 = 8'hC3; b8 = 8'h5A; bin8 = 1'b1; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      repeat (3) tick();
      check("busy8_midrun", 32'(busy8), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy8", 32'(busy8), 0);
      check("abort_done8", 32'(done8), 0);
      check("abort_diff8", 32'(diff8), 0);
      check("abort_bout8", 32'(bout8), 0);
      done_n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8) done_n++;
      end
      check("abort_no_done", done_n, 0);
      run8(8'h05, 8'h03, 1'b0, 0);

      for (int i = 0; i < 20; i++) begin
         run8(8'($urandom), 8'($urandom), 1'($urandom), 0);
      end

      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
               run4(4'(ai), 4'(bi), 1'(ci));
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
